gpr_file_sb: RTL and testbench

Parametrised general-purpose register file with two write ports, combinational read forwarding and a per-register pending-write scoreboard.
- Port A: single-cycle ALU writeback.
- Port B: late writeback for loads and multi-cycle ops, with byte enables.
- Sits between decode (read and issue) and the writeback stages. Stall logic uses the busy outputs.

---
 rtl/gpr_file_sb_pkg.sv | 21 ++
 rtl/gpr_file_sb_if.sv | 33 +++
 rtl/gpr_file_sb_scoreboard.sv | 43 ++++
 rtl/gpr_file_sb.sv | 83 ++++++++
 tb/tb_gpr_file_sb.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_file_sb_pkg.sv
// rtl/gpr_file_sb_pkg.sv - shared widths and byte-merge helper for the register file
package gpr_file_sb_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam int DW_MAX = 256;
    localparam int BE_MAX = DW_MAX / 8;

    // Operates on the widest supported word; callers zero-extend and truncate.
    function automatic logic [DW_MAX-1:0] merge_be(input logic [DW_MAX-1:0] old_w,
                                                   input logic [DW_MAX-1:0] new_w,
                                                   input logic [BE_MAX-1:0] be);
        logic [DW_MAX-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_MAX; i++) begin
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/gpr_file_sb_if.sv
// rtl/gpr_file_sb_if.sv - read, write, issue and status signals of the register file
interface gpr_file_sb_if #(parameter int DW = 32, parameter int AW = 5);

    logic [AW-1:0]   rs_addr;
    logic [AW-1:0]   rt_addr;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    logic            rs_busy;
    logic            rt_busy;
    logic            wa_en;
    logic [AW-1:0]   wa_addr;
    logic [DW-1:0]   wa_data;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [DW/8-1:0] wb_be;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic [AW:0]     busy_cnt;

    modport master (
        output rs_addr, rt_addr, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, wb_be, iss_en, iss_addr,
        input  rs_data, rt_data, rs_busy, rt_busy, busy_cnt
    );

    modport slave (
        input  rs_addr, rt_addr, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, wb_be, iss_en, iss_addr,
        output rs_data, rt_data, rs_busy, rt_busy, busy_cnt
    );

endinterface

// File: rtl/gpr_file_sb_scoreboard.sv
// rtl/gpr_file_sb_scoreboard.sv - pending-write bits and registered pending count
module gpr_scoreboard #(
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    output logic [(1<<AW)-1:0] busy,
    output logic [AW:0]       busy_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [DEPTH-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;

    // Issue is applied after the clear so a same-cycle reissue keeps the bit set.
    always_comb begin
        busy_nxt = busy;
        if (wb_en) busy_nxt[wb_addr] = 1'b0;
        if (iss_en && !(ZERO_REG != 0 && iss_addr == '0)) busy_nxt[iss_addr] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/gpr_file_sb.sv
// rtl/gpr_file_sb.sv - dual-write register file with read forwarding and pending-write scoreboard
module gpr_file_sb
    import gpr_file_sb_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic        clk,
    input logic        rst,
    gpr_file_sb_if.slave bus
);

    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [AW-1:0]    rd_addr [2];
    logic [DW-1:0]    rd_data [2];
    logic             rd_busy [2];

    function automatic logic [DW-1:0] merge_w(input logic [DW-1:0] old_w,
                                              input logic [DW-1:0] new_w,
                                              input logic [NB-1:0] be);
        return DW'(merge_be(DW_MAX'(old_w), DW_MAX'(new_w), BE_MAX'(be)));
    endfunction

    // Port A is the younger instruction, so it takes every byte on a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!(ZERO_REG != 0 && i == 0)) begin
                    if (bus.wa_en && bus.wa_addr == AW'(i))
                        regs[i] <= bus.wa_data;
                    else if (bus.wb_en && bus.wb_addr == AW'(i))
                        regs[i] <= merge_w(regs[i], bus.wb_data, bus.wb_be);
                end
            end
        end
    end

    gpr_scoreboard #(.AW(AW), .ZERO_REG(ZERO_REG)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .wb_en    (bus.wb_en),
        .wb_addr  (bus.wb_addr),
        .busy     (busy),
        .busy_cnt (bus.busy_cnt)
    );

    assign rd_addr[0] = bus.rs_addr;
    assign rd_addr[1] = bus.rt_addr;

    // Forwarded data must not leak out while reset is held.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
            if (BYPASS != 0 && bus.wb_en && bus.wb_addr == rd_addr[p]) begin
                rd_data[p] = merge_w(regs[rd_addr[p]], bus.wb_data, bus.wb_be);
                rd_busy[p] = 1'b0;
            end
            if (BYPASS != 0 && bus.wa_en && bus.wa_addr == rd_addr[p])
                rd_data[p] = bus.wa_data;
            if ((ZERO_REG != 0 && rd_addr[p] == '0) || !rst) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign bus.rs_data = rd_data[0];
    assign bus.rt_data = rd_data[1];
    assign bus.rs_busy = rd_busy[0];
    assign bus.rt_busy = rd_busy[1];

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb/tb_gpr_file_sb.sv - randomized and directed bench for gpr_file_sb against a behavioural model
module tb_gpr_file_sb;

    logic clk;
    logic rst;

    gpr_file_sb_if #(.DW(32), .AW(5)) bus0 ();
    gpr_file_sb_if #(.DW(32), .AW(5)) bus1 ();

    gpr_file_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    gpr_file_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.rs_addr  = bus0.rs_addr;
    assign bus1.rt_addr  = bus0.rt_addr;
    assign bus1.wa_en    = bus0.wa_en;
    assign bus1.wa_addr  = bus0.wa_addr;
    assign bus1.wa_data  = bus0.wa_data;
    assign bus1.wb_en    = bus0.wb_en;
    assign bus1.wb_addr  = bus0.wb_addr;
    assign bus1.wb_data  = bus0.wb_data;
    assign bus1.wb_be    = bus0.wb_be;
    assign bus1.iss_en   = bus0.iss_en;
    assign bus1.iss_addr = bus0.iss_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          m_cnt;

    function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (byp && bus0.wa_en && bus0.wa_addr == a) return bus0.wa_data;
        if (byp && bus0.wb_en && bus0.wb_addr == a) return byte_merge(m_mem[a], bus0.wb_data, bus0.wb_be);
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input bit byp, input logic [4:0] a);
        return m_busy[a] && !(byp && bus0.wb_en && bus0.wb_addr == a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic idle();
        bus0.wa_en = 1'b0; bus0.wa_addr = '0; bus0.wa_data = '0;
        bus0.wb_en = 1'b0; bus0.wb_addr = '0; bus0.wb_data = '0; bus0.wb_be = '0;
        bus0.iss_en = 1'b0; bus0.iss_addr = '0;
    endtask

    // Advance one edge, apply the architectural effect of the current inputs to the model.
    task automatic cycle();
        @(posedge clk);
        if (bus0.wa_en && bus0.wa_addr != 0) m_mem[bus0.wa_addr] = bus0.wa_data;
        if (bus0.wb_en && bus0.wb_addr != 0 && !(bus0.wa_en && bus0.wa_addr == bus0.wb_addr))
            m_mem[bus0.wb_addr] = byte_merge(m_mem[bus0.wb_addr], bus0.wb_data, bus0.wb_be);
        if (bus0.wb_en) m_busy[bus0.wb_addr] = 1'b0;
        if (bus0.iss_en && bus0.iss_addr != 0) m_busy[bus0.iss_addr] = 1'b1;
        m_cnt = 0;
        for (int i = 0; i < 32; i++) m_cnt += int'(m_busy[i]);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        model_reset();
        bus0.rs_addr = 5'd3; bus0.rt_addr = 5'd3;
        bus0.wa_en = 1'b1; bus0.wa_addr = 5'd3; bus0.wa_data = 32'hCAFE_F00D;
        bus0.iss_en = 1'b1; bus0.iss_addr = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus0.rs_data !== 32'd0) begin n_bad++; $display("FAIL reset_rs_data: got %h want 0", bus0.rs_data); end
        n_cmp++; if (bus0.rt_busy !== 1'b0) begin n_bad++; $display("FAIL reset_rt_busy: got %b want 0", bus0.rt_busy); end
        n_cmp++; if (bus0.busy_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_busy_cnt: got %0d want 0", bus0.busy_cnt); end
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus1.rs_data !== 32'd0) begin n_bad++; $display("FAIL reset_release_r3: got %h want 0", bus1.rs_data); end
    endtask

    task automatic test_zero_reg();
        @(posedge clk); #1;
        bus0.rs_addr = 5'd0;
        bus0.wa_en = 1'b1; bus0.wa_addr = 5'd0; bus0.wa_data = 32'h0000_FFFF;
        bus0.iss_en = 1'b1; bus0.iss_addr = 5'd0;
        #1;
        n_cmp++; if (bus0.rs_data !== 32'd0) begin n_bad++; $display("FAIL zero_fwd: got %h want 0", bus0.rs_data); end
        cycle(); idle(); #1;
        n_cmp++; if (bus0.rs_data !== 32'd0) begin n_bad++; $display("FAIL zero_data: got %h want 0", bus0.rs_data); end
        n_cmp++; if (bus0.rs_busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", bus0.rs_busy); end
        n_cmp++; if (bus0.busy_cnt !== 6'd0) begin n_bad++; $display("FAIL zero_busy_cnt: got %0d want 0", bus0.busy_cnt); end
    endtask

    task automatic test_forwarding();
        bus0.rs_addr = 5'd3;
        bus0.wa_en = 1'b1; bus0.wa_addr = 5'd3; bus0.wa_data = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (bus0.rs_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL fwd_bypass: got %h want deadbeef", bus0.rs_data); end
        n_cmp++; if (bus1.rs_data !== 32'd0) begin n_bad++; $display("FAIL fwd_nobypass_before: got %h want 0", bus1.rs_data); end
        cycle(); idle(); #1;
        n_cmp++; if (bus1.rs_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL fwd_nobypass_after: got %h want deadbeef", bus1.rs_data); end
    endtask

    task automatic test_byte_enable();
        bus0.rs_addr = 5'd7;
        bus0.wa_en = 1'b1; bus0.wa_addr = 5'd7; bus0.wa_data = 32'h1122_3344;
        cycle(); idle();
        bus0.wb_en = 1'b1; bus0.wb_addr = 5'd7; bus0.wb_data = 32'hAABB_CCDD; bus0.wb_be = 4'b0101;
        #1;
        n_cmp++; if (bus0.rs_data !== 32'h11BB_33DD) begin n_bad++; $display("FAIL be_fwd: got %h want 11bb33dd", bus0.rs_data); end
        n_cmp++; if (bus1.rs_data !== 32'h1122_3344) begin n_bad++; $display("FAIL be_nobypass_before: got %h want 11223344", bus1.rs_data); end
        cycle(); idle(); #1;
        n_cmp++; if (bus1.rs_data !== 32'h11BB_33DD) begin n_bad++; $display("FAIL be_stored: got %h want 11bb33dd", bus1.rs_data); end
    endtask

    task automatic test_collision();
        int cnt_before;
        cnt_before = m_cnt;
        bus0.rs_addr = 5'd9;
        bus0.iss_en = 1'b1; bus0.iss_addr = 5'd9;
        cycle(); idle(); #1;
        n_cmp++; if (bus0.busy_cnt !== 6'(cnt_before + 1)) begin n_bad++; $display("FAIL coll_issue_cnt: got %0d want %0d", bus0.busy_cnt, cnt_before + 1); end
        n_cmp++; if (bus0.rs_busy !== 1'b1) begin n_bad++; $display("FAIL coll_issue_busy: got %b want 1", bus0.rs_busy); end
        bus0.wa_en = 1'b1; bus0.wa_addr = 5'd9; bus0.wa_data = 32'h1;
        bus0.wb_en = 1'b1; bus0.wb_addr = 5'd9; bus0.wb_data = 32'h2; bus0.wb_be = 4'hF;
        #1;
        n_cmp++; if (bus0.rs_data !== 32'h1) begin n_bad++; $display("FAIL coll_fwd: got %h want 1", bus0.rs_data); end
        cycle(); idle(); #1;
        n_cmp++; if (bus1.rs_data !== 32'h1) begin n_bad++; $display("FAIL coll_stored: got %h want 1", bus1.rs_data); end
        n_cmp++; if (bus1.rs_busy !== 1'b0) begin n_bad++; $display("FAIL coll_busy: got %b want 0", bus1.rs_busy); end
        n_cmp++; if (bus0.busy_cnt !== 6'(cnt_before)) begin n_bad++; $display("FAIL coll_cnt: got %0d want %0d", bus0.busy_cnt, cnt_before); end
    endtask

    task automatic test_sb_race();
        int cnt_issued;
        bus0.rt_addr = 5'd4;
        bus0.iss_en = 1'b1; bus0.iss_addr = 5'd4;
        cycle(); idle(); #1;
        cnt_issued = m_cnt;
        bus0.iss_en = 1'b1; bus0.iss_addr = 5'd4;
        bus0.wb_en = 1'b1; bus0.wb_addr = 5'd4; bus0.wb_data = 32'h5555_5555; bus0.wb_be = 4'h0;
        #1;
        n_cmp++; if (bus0.rt_busy !== 1'b0) begin n_bad++; $display("FAIL race_rt_busy_fwd: got %b want 0", bus0.rt_busy); end
        n_cmp++; if (bus1.rt_busy !== 1'b1) begin n_bad++; $display("FAIL race_rt_busy_nobypass: got %b want 1", bus1.rt_busy); end
        cycle(); idle(); #1;
        n_cmp++; if (bus0.rt_busy !== 1'b1) begin n_bad++; $display("FAIL race_rt_busy_next: got %b want 1", bus0.rt_busy); end
        n_cmp++; if (bus0.busy_cnt !== 6'(cnt_issued)) begin n_bad++; $display("FAIL race_cnt: got %0d want %0d", bus0.busy_cnt, cnt_issued); end
        n_cmp++; if (bus0.rt_data !== 32'd0) begin n_bad++; $display("FAIL race_be0_data: got %h want 0", bus0.rt_data); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [4:0] rs, rt;
            rs = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rt = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            bus0.rs_addr  = rs;
            bus0.rt_addr  = rt;
            bus0.wa_en    = ($urandom_range(0, 2) == 0);
            bus0.wa_addr  = 5'($urandom_range(0, 7));
            bus0.wa_data  = $urandom;
            bus0.wb_en    = ($urandom_range(0, 2) == 0);
            bus0.wb_addr  = 5'($urandom_range(0, 7));
            bus0.wb_data  = $urandom;
            bus0.wb_be    = 4'($urandom);
            bus0.iss_en   = ($urandom_range(0, 2) == 0);
            bus0.iss_addr = 5'($urandom_range(0, 7));
            #1;
            n_cmp++; if (bus0.rs_data !== exp_rd(1, rs)) begin n_bad++; $display("FAIL rnd_rs_data c=%0d: got %h want %h", c, bus0.rs_data, exp_rd(1, rs)); end
            n_cmp++; if (bus0.rt_data !== exp_rd(1, rt)) begin n_bad++; $display("FAIL rnd_rt_data c=%0d: got %h want %h", c, bus0.rt_data, exp_rd(1, rt)); end
            n_cmp++; if (bus1.rs_data !== exp_rd(0, rs)) begin n_bad++; $display("FAIL rnd_rs_data_nb c=%0d: got %h want %h", c, bus1.rs_data, exp_rd(0, rs)); end
            n_cmp++; if (bus0.rs_busy !== exp_busy(1, rs)) begin n_bad++; $display("FAIL rnd_rs_busy c=%0d: got %b want %b", c, bus0.rs_busy, exp_busy(1, rs)); end
            n_cmp++; if (bus0.rt_busy !== exp_busy(1, rt)) begin n_bad++; $display("FAIL rnd_rt_busy c=%0d: got %b want %b", c, bus0.rt_busy, exp_busy(1, rt)); end
            n_cmp++; if (bus1.rt_busy !== exp_busy(0, rt)) begin n_bad++; $display("FAIL rnd_rt_busy_nb c=%0d: got %b want %b", c, bus1.rt_busy, exp_busy(0, rt)); end
            cycle();
            n_cmp++; if (bus0.busy_cnt !== 6'(m_cnt)) begin n_bad++; $display("FAIL rnd_busy_cnt c=%0d: got %0d want %0d", c, bus0.busy_cnt, m_cnt); end
        end
        idle();
    endtask

    task automatic test_reset_midrun();
        bus0.iss_en = 1'b1; bus0.iss_addr = 5'd6;
        bus0.wa_en = 1'b1; bus0.wa_addr = 5'd5; bus0.wa_data = 32'h0000_1234;
        cycle(); idle();
        bus0.rs_addr = 5'd5;
        #1;
        n_cmp++; if (bus1.rs_data !== 32'h0000_1234) begin n_bad++; $display("FAIL mid_pre_data: got %h want 1234", bus1.rs_data); end
        bus0.iss_en = 1'b1; bus0.iss_addr = 5'd7;
        #1 rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus0.rs_data !== 32'd0) begin n_bad++; $display("FAIL mid_rs_data: got %h want 0", bus0.rs_data); end
        n_cmp++; if (bus0.busy_cnt !== 6'd0) begin n_bad++; $display("FAIL mid_busy_cnt: got %0d want 0", bus0.busy_cnt); end
        idle();
        #2 rst = 1'b1;
        cycle(); #1;
        n_cmp++; if (bus1.rs_data !== 32'd0) begin n_bad++; $display("FAIL mid_after_data: got %h want 0", bus1.rs_data); end
        n_cmp++; if (bus0.busy_cnt !== 6'd0) begin n_bad++; $display("FAIL mid_after_cnt: got %0d want 0", bus0.busy_cnt); end
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_forwarding();
        test_byte_enable();
        test_collision();
        test_sb_race();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
